// File: rtl/dcache_direct.sv
// rtl/dcache_direct.sv - direct-mapped, write-through, no-write-allocate data cache
module dcache_direct #(
  parameter int LINES    = 16,
  parameter int MISS_LAT = 4
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);
  localparam int IDXW = $clog2(LINES);
  localparam int TAGW = 30 - IDXW;
  localparam int CNTW = (MISS_LAT > 1) ? $clog2(MISS_LAT) : 1;
  localparam logic [CNTW-1:0] CNT_INIT = CNTW'(MISS_LAT - 1);

  typedef enum logic [1:0] {IDLE, RFILL, WBUSY, WDONE} state_t;

  state_t            state_q;
  logic [CNTW-1:0]   cnt_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [LINES-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES];

  logic [IDXW-1:0] cpu_idx, lat_idx;
  logic [TAGW-1:0] cpu_tag, lat_tag;
  logic            cpu_hit, lat_hit, cnt_zero;
  logic            unused_addr_bits;

  assign cpu_idx  = cpu_addr[IDXW+1:2];
  assign cpu_tag  = cpu_addr[31:IDXW+2];
  assign lat_idx  = mem_addr_q[IDXW+1:2];
  assign lat_tag  = mem_addr_q[31:IDXW+2];
  assign cpu_hit  = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign lat_hit  = valid_q[lat_idx] && (tag_q[lat_idx] == lat_tag);
  assign cnt_zero = (cnt_q == '0);
  assign unused_addr_bits = ^cpu_addr[1:0];

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = (state_q == WBUSY) && cnt_zero;

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we || !cpu_hit) cpu_stall = 1'b1;
          else                    cpu_rdata = data_q[cpu_idx];
        end
      end
      RFILL, WBUSY: cpu_stall = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      valid_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            mem_addr_q  <= {cpu_addr[31:2], 2'b00};
            mem_wdata_q <= cpu_wdata;
            cnt_q       <= CNT_INIT;
            state_q     <= WBUSY;
          end else if (cpu_req && !cpu_hit) begin
            mem_addr_q  <= {cpu_addr[31:2], 2'b00};
            cnt_q       <= CNT_INIT;
            state_q     <= RFILL;
          end
        end
        RFILL: begin
          if (!cnt_zero) begin
            cnt_q <= cnt_q - CNTW'(1);
          end else begin
            valid_q[lat_idx] <= 1'b1;
            state_q          <= IDLE;
          end
        end
        WBUSY: begin
          if (!cnt_zero) cnt_q   <= cnt_q - CNTW'(1);
          else           state_q <= WDONE;
        end
        WDONE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag/data carry no reset; writes only happen in states that reset forces away from.
  always_ff @(posedge clock) begin
    if (state_q == RFILL && cnt_zero) begin
      data_q[lat_idx] <= mem_rdata;
      tag_q[lat_idx]  <= lat_tag;
    end else if (mem_we && lat_hit) begin
      data_q[lat_idx] <= mem_wdata_q;
    end
  end

endmodule

// File: tb/tb_dcache_direct.sv
// tb/tb_dcache_direct.sv - directed self-checking bench for dcache_direct
module tb_dcache_direct;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req    [2];
  logic        we     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic        stall  [2];
  logic [31:0] maddr  [2];
  logic [31:0] mwdata [2];
  logic        mwe    [2];
  logic [31:0] mrdata [2];
  logic [31:0] mem    [2][256];
  int          we_total [2] = '{0, 0};
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  dcache_direct #(.LINES(16), .MISS_LAT(4)) u_dut0 (
    .clock(clock), .resetn(resetn),
    .cpu_req(req[0]), .cpu_we(we[0]), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]),
    .cpu_rdata(rdata[0]), .cpu_stall(stall[0]),
    .mem_addr(maddr[0]), .mem_wdata(mwdata[0]), .mem_we(mwe[0]), .mem_rdata(mrdata[0])
  );

  dcache_direct #(.LINES(16), .MISS_LAT(1)) u_dut1 (
    .clock(clock), .resetn(resetn),
    .cpu_req(req[1]), .cpu_we(we[1]), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]),
    .cpu_rdata(rdata[1]), .cpu_stall(stall[1]),
    .mem_addr(maddr[1]), .mem_wdata(mwdata[1]), .mem_we(mwe[1]), .mem_rdata(mrdata[1])
  );

  // Word memory models: combinational read, write on rising edge.
  assign mrdata[0] = mem[0][maddr[0][9:2]];
  assign mrdata[1] = mem[1][maddr[1][9:2]];

  always @(posedge clock) begin
    if (mwe[0]) mem[0][maddr[0][9:2]] <= mwdata[0];
    if (mwe[1]) mem[1][maddr[1][9:2]] <= mwdata[1];
  end

  always @(negedge clock) begin
    if (mwe[0]) we_total[0] <= we_total[0] + 1;
    if (mwe[1]) we_total[1] <= we_total[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic load_op(input int d, input string tag, input logic [31:0] a,
                         input logic [31:0] exp_data, input int exp_stall);
    int n;
    n = 0;
    req[d] = 1'b1; we[d] = 1'b0; addr[d] = a;
    @(negedge clock);
    while (stall[d] && n < 50) begin
      n++;
      @(negedge clock);
    end
    check({tag, "_stall"}, 32'(n), 32'(exp_stall));
    check({tag, "_data"}, rdata[d], exp_data);
    @(posedge clock); #1;
    req[d] = 1'b0;
  endtask

  task automatic store_op(input int d, input string tag, input logic [31:0] a,
                          input logic [31:0] dat, input int exp_stall);
    int n, we_n, we_at;
    logic [31:0] wa, wd;
    n = 0; we_n = 0; we_at = 0; wa = '0; wd = '0;
    req[d] = 1'b1; we[d] = 1'b1; addr[d] = a; wdata[d] = dat;
    @(negedge clock);
    while (stall[d] && n < 50) begin
      n++;
      if (mwe[d]) begin
        we_n++; we_at = n; wa = maddr[d]; wd = mwdata[d];
      end
      @(negedge clock);
    end
    if (mwe[d]) we_n++;
    check({tag, "_stall"}, 32'(n), 32'(exp_stall));
    check({tag, "_we_pulses"}, 32'(we_n), 32'd1);
    check({tag, "_we_cycle"}, 32'(we_at), 32'(exp_stall));
    check({tag, "_mem_addr"}, wa, a);
    check({tag, "_mem_wdata"}, wd, dat);
    @(posedge clock); #1;
    req[d] = 1'b0; we[d] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[0][i] = 32'hA5A5_0000 | 32'(i);
      mem[1][i] = 32'hA5A5_0000 | 32'(i);
    end
    mem[0][16] = 32'h0000_1234;
    mem[1][16] = 32'h0000_1234;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
    end

    resetn = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_stall", {31'd0, stall[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_mem_we", {31'd0, mwe[0]}, 32'd0);
    check("rst_mem_addr", maddr[0], 32'd0);
    check("rst_mem_wdata", mwdata[0], 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    load_op(0, "miss40", 32'h40, 32'h0000_1234, 5);
    load_op(0, "hit40", 32'h40, 32'h0000_1234, 0);
    load_op(0, "evict00", 32'h00, 32'hA5A5_0000, 5);
    load_op(0, "reload40", 32'h40, 32'h0000_1234, 5);
    store_op(0, "st_hit40", 32'h40, 32'hDEAD_BEEF, 5);
    load_op(0, "hit40_new", 32'h40, 32'hDEAD_BEEF, 0);
    store_op(0, "st_miss80", 32'h80, 32'h0000_CAFE, 5);
    load_op(0, "miss80", 32'h80, 32'h0000_CAFE, 5);
    load_op(0, "hit80", 32'h80, 32'h0000_CAFE, 0);
    check("we_total_stores_only", 32'(we_total[0]), 32'd2);

    // Reset in the second RFILL cycle
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h100;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("rfill_stall", {31'd0, stall[0]}, 32'd1);
    check("rfill_mem_addr", maddr[0], 32'h100);
    resetn = 1'b0; req[0] = 1'b0;
    #1;
    check("rfill_rst_stall", {31'd0, stall[0]}, 32'd0);
    check("rfill_rst_mem_we", {31'd0, mwe[0]}, 32'd0);
    check("rfill_rst_mem_addr", maddr[0], 32'd0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Reset in the second WBUSY cycle: the store must never reach memory
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h1111_2222;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("wbusy_stall", {31'd0, stall[0]}, 32'd1);
    resetn = 1'b0; req[0] = 1'b0; we[0] = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    resetn = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("wbusy_rst_no_we", 32'(we_total[0]), 32'd2);
    check("wbusy_rst_mem", mem[0][16], 32'hDEAD_BEEF);
    load_op(0, "post_rst40", 32'h40, 32'hDEAD_BEEF, 5);

    // MISS_LAT = 1 instance
    load_op(1, "l1_miss40", 32'h40, 32'h0000_1234, 2);
    load_op(1, "l1_hit40", 32'h40, 32'h0000_1234, 0);
    store_op(1, "l1_st44", 32'h44, 32'h0000_5A5A, 2);
    check("l1_mem17", mem[1][17], 32'h0000_5A5A);
    load_op(1, "l1_miss44", 32'h44, 32'h0000_5A5A, 2);
    check("l1_we_total", 32'(we_total[1]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
